// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Fixed latency of N+1 cycles from acceptance to the done pulse (N = 64 or 32 for W-forms).
package muldiv_pkg;
  localparam int unsigned XLEN = 64;
  localparam int unsigned WLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIV  = 4'd11,
    ALU_REM  = 4'd12
  } alufunc_t;
endpackage

module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  alufunc_t        func,
  input  logic            unsign,
  input  logic            word,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic            legal_c, accept_c;
  logic [CNT_W-1:0] cnt;
  alufunc_t        op_q;
  logic            word_q, q_neg_q, r_neg_q;
  logic [XLEN-1:0] acc_q, x_q, y_q;
  logic [XLEN-1:0] acc_nxt, x_nxt, y_nxt;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] res_raw, res_c;
  logic            sgn_a, sgn_b, a_neg, b_neg, b_zero;
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b;

  // FSM next state and acceptance
  always_comb begin
    state_nxt = state;
    legal_c   = (func == ALU_MUL) || (func == ALU_DIV) || (func == ALU_REM);
    accept_c  = 1'b0;
    if (state == IDLE) accept_c = start && legal_c && !flush;
    case (state)
      IDLE:    if (accept_c) state_nxt = CALC;
      CALC: begin
        if (flush)                   state_nxt = IDLE;
        else if (cnt == CNT_W'(1))   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stall = (state == CALC) || accept_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand conditioning at acceptance: extension and magnitude for signed division
  always_comb begin
    sgn_a  = word ? srca[WLEN-1] : srca[XLEN-1];
    sgn_b  = word ? srcb[WLEN-1] : srcb[XLEN-1];
    a_neg  = !unsign && sgn_a;
    b_neg  = !unsign && sgn_b;
    ext_a  = srca;
    ext_b  = srcb;
    if (word) begin
      ext_a = unsign ? XLEN'(srca[WLEN-1:0]) : {{WLEN{srca[WLEN-1]}}, srca[WLEN-1:0]};
      ext_b = unsign ? XLEN'(srcb[WLEN-1:0]) : {{WLEN{srcb[WLEN-1]}}, srcb[WLEN-1:0]};
    end
    mag_a  = a_neg ? -ext_a : ext_a;
    mag_b  = b_neg ? -ext_b : ext_b;
    b_zero = word ? (srcb[WLEN-1:0] == '0) : (srcb == '0);
  end

  // One radix-2 iteration; x holds the multiplicand or the dividend/quotient shift register
  always_comb begin
    acc_nxt = acc_q;
    x_nxt   = x_q;
    y_nxt   = y_q;
    rem_sh  = {acc_q, x_q[XLEN-1]};
    if (op_q == ALU_MUL) begin
      acc_nxt = y_q[0] ? acc_q + x_q : acc_q;
      x_nxt   = {x_q[XLEN-2:0], 1'b0};
      y_nxt   = {1'b0, y_q[XLEN-1:1]};
    end else if (rem_sh >= {1'b0, y_q}) begin
      acc_nxt = rem_sh[XLEN-1:0] - y_q;
      x_nxt   = {x_q[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = rem_sh[XLEN-1:0];
      x_nxt   = {x_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and W-form extension of the final iteration's value
  always_comb begin
    case (op_q)
      ALU_MUL: res_raw = acc_nxt;
      ALU_DIV: res_raw = q_neg_q ? -x_nxt : x_nxt;
      default: res_raw = r_neg_q ? -acc_nxt : acc_nxt;
    endcase
    res_c = word_q ? {{WLEN{res_raw[WLEN-1]}}, res_raw[WLEN-1:0]} : res_raw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      op_q    <= ALU_ADD;
      word_q  <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state_nxt == DONE);
      if (accept_c) begin
        op_q   <= func;
        word_q <= word;
        cnt    <= word ? CNT_W'(WLEN) : CNT_W'(XLEN);
        acc_q  <= '0;
        if (func == ALU_MUL) begin
          x_q     <= srca;
          y_q     <= srcb;
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
        end else begin
          // W-form dividend sits in the upper half so 32 shifts consume it
          x_q     <= word ? {mag_a[WLEN-1:0], WLEN'(0)} : mag_a;
          y_q     <= mag_b;
          q_neg_q <= (a_neg ^ b_neg) && !b_zero;
          r_neg_q <= a_neg;
        end
      end else if (state == CALC && !flush) begin
        acc_q <= acc_nxt;
        x_q   <= x_nxt;
        y_q   <= y_nxt;
        cnt   <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) result <= res_c;
      end
    end
  end

endmodule
